// File: rtl/ym3438_write_sched.sv
// Host-side register-write scheduler for the YM3438 core.
// Buffers (bank, addr, data) requests in a FIFO and replays them onto the
// chip pins as an address phase (skipped on an address-cache hit), a data
// phase, and a post-write busy wait.
module ym3438_write_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned ADDR_GAP    = 2,
  parameter int unsigned BUSY_CYCLES = 96
) (
  input  logic                          MCLK,
  input  logic                          IC,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_bank,
  input  logic [7:0]                    req_addr,
  input  logic [7:0]                    req_data,
  output logic                          YM_CS,
  output logic                          YM_WR,
  output logic                          YM_RD,
  output logic [1:0]                    YM_ADDRESS,
  output logic [7:0]                    YM_DATA,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_A = (WR_CYCLES > ADDR_GAP) ? WR_CYCLES : ADDR_GAP;
  localparam int unsigned MAX_N = (MAX_A > BUSY_CYCLES) ? MAX_A : BUSY_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_N) + 1;

  localparam logic [AW:0]   DEPTH_C   = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(ADDR_GAP - 1);
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, A_SET, A_WR, A_GAP, D_SET, D_WR, D_WAIT} state_t;

  // FIFO storage: {bank, addr, data}
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [16:0]   head;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wk_bank;
  logic [7:0]    wk_addr, wk_data;
  logic          cache_valid, cache_load, cache_hit;
  logic [8:0]    cache_key;
  logic          cs_nxt, wr_nxt;
  logic [1:0]    addr_nxt;
  logic [7:0]    data_nxt;

  assign req_ready  = (count < DEPTH_C);
  assign push       = req_valid & req_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);
  assign YM_RD      = 1'b1;
  assign cache_hit  = cache_valid && (cache_key == head[16:8]);

  // FIFO payload write; storage needs no reset since occupancy is tracked by count
  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= {req_bank, req_addr, req_data};
  end

  // FIFO pointers and occupancy; push while full is refused through req_ready
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Next state, phase counter and next pin values; pins are registered so
  // each value is computed one cycle early from the state being entered
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt != '0) ? cnt - CW'(1) : cnt;
    pop        = 1'b0;
    cache_load = 1'b0;
    cs_nxt     = YM_CS;
    wr_nxt     = YM_WR;
    addr_nxt   = YM_ADDRESS;
    data_nxt   = YM_DATA;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          cnt_nxt = '0;
          cs_nxt  = 1'b0;
          wr_nxt  = 1'b1;
          if (cache_hit) begin
            state_nxt = D_SET;
            addr_nxt  = {head[16], 1'b1};
            data_nxt  = head[7:0];
          end else begin
            state_nxt = A_SET;
            addr_nxt  = {head[16], 1'b0};
            data_nxt  = head[15:8];
          end
        end
      end
      A_SET: begin
        state_nxt = A_WR;
        cnt_nxt   = WR_LOAD;
        wr_nxt    = 1'b0;
      end
      A_WR: begin
        if (cnt == '0) begin
          state_nxt  = A_GAP;
          cnt_nxt    = GAP_LOAD;
          cs_nxt     = 1'b1;
          wr_nxt     = 1'b1;
          cache_load = 1'b1;
        end
      end
      A_GAP: begin
        if (cnt == '0) begin
          state_nxt = D_SET;
          cnt_nxt   = '0;
          cs_nxt    = 1'b0;
          addr_nxt  = {wk_bank, 1'b1};
          data_nxt  = wk_data;
        end
      end
      D_SET: begin
        state_nxt = D_WR;
        cnt_nxt   = WR_LOAD;
        wr_nxt    = 1'b0;
      end
      D_WR: begin
        if (cnt == '0) begin
          state_nxt = D_WAIT;
          cnt_nxt   = BUSY_LOAD;
          cs_nxt    = 1'b1;
          wr_nxt    = 1'b1;
        end
      end
      D_WAIT: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, working register, address cache and pin registers
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      state       <= IDLE;
      cnt         <= '0;
      wk_bank     <= 1'b0;
      wk_addr     <= '0;
      wk_data     <= '0;
      cache_valid <= 1'b0;
      cache_key   <= '0;
      YM_CS       <= 1'b1;
      YM_WR       <= 1'b1;
      YM_ADDRESS  <= '0;
      YM_DATA     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      YM_CS      <= cs_nxt;
      YM_WR      <= wr_nxt;
      YM_ADDRESS <= addr_nxt;
      YM_DATA    <= data_nxt;
      if (pop) begin
        wk_bank <= head[16];
        wk_addr <= head[15:8];
        wk_data <= head[7:0];
      end
      if (cache_load) begin
        cache_valid <= 1'b1;
        cache_key   <= {wk_bank, wk_addr};
      end
    end
  end

endmodule

// File: tb/tb_ym3438_write_sched.sv
// Self-checking bench for ym3438_write_sched: directed scenarios plus random
// bursts, checked against a transaction-level model of the expected WR pulses.
module tb_ym3438_write_sched;

  localparam int DEPTH = 4;
  localparam int WRC   = 2;
  localparam int GAP   = 2;
  localparam int BUSYC = 96;
  localparam int T_UNC = 1 + WRC + GAP + 1 + WRC + BUSYC;
  localparam int T_CAC = 1 + WRC + BUSYC;

  logic       MCLK = 1'b0;
  logic       IC;
  logic       req_valid, req_ready, req_bank;
  logic [7:0] req_addr, req_data;
  logic       YM_CS, YM_WR, YM_RD;
  logic [1:0] YM_ADDRESS;
  logic [7:0] YM_DATA;
  logic       busy;
  logic [2:0] fifo_count;

  ym3438_write_sched #(
    .FIFO_DEPTH (DEPTH),
    .WR_CYCLES  (WRC),
    .ADDR_GAP   (GAP),
    .BUSY_CYCLES(BUSYC)
  ) dut (
    .MCLK      (MCLK),
    .IC        (IC),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bank  (req_bank),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .YM_CS     (YM_CS),
    .YM_WR     (YM_WR),
    .YM_RD     (YM_RD),
    .YM_ADDRESS(YM_ADDRESS),
    .YM_DATA   (YM_DATA),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  typedef struct { logic [1:0] a; logic [7:0] d; int w; bit st; int fall; } pulse_t;
  typedef struct { logic [1:0] a; logic [7:0] d; } epulse_t;
  typedef struct { logic b; logic [7:0] a; logic [7:0] d; } req_t;

  pulse_t  obs_q[$];
  epulse_t exp_q[$];
  req_t    rq[$];

  int n_chk  = 0;
  int n_pass = 0;

  // model address cache
  bit         m_cv = 0;
  logic [8:0] m_key = '0;

  // pin monitor: records each WR-low pulse with its width and whether
  // address/data were set up a full cycle ahead and held throughout
  pulse_t     cur;
  bit         in_p = 0;
  logic       p_wr = 1'b1, p_cs = 1'b1;
  logic [1:0] p_a = '0;
  logic [7:0] p_d = '0;
  always @(negedge MCLK) begin
    if (in_p) begin
      if (YM_WR === 1'b0) begin
        cur.w++;
        if (YM_ADDRESS !== cur.a || YM_DATA !== cur.d || YM_CS !== 1'b0) cur.st = 0;
      end else begin
        obs_q.push_back(cur);
        in_p = 0;
      end
    end else if (YM_WR === 1'b0 && p_wr === 1'b1) begin
      cur.a    = YM_ADDRESS;
      cur.d    = YM_DATA;
      cur.w    = 1;
      cur.fall = cyc;
      cur.st   = (p_cs === 1'b0 && p_a === YM_ADDRESS && p_d === YM_DATA && YM_CS === 1'b0);
      in_p     = 1;
    end
    p_wr = YM_WR;
    p_cs = YM_CS;
    p_a  = YM_ADDRESS;
    p_d  = YM_DATA;
  end

  task automatic tick();
    @(negedge MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // expected pin pulses and duration of one write, from the cache rule
  function automatic int model_write(input req_t r);
    bit hit;
    hit = m_cv && (m_key == {r.b, r.a});
    if (!hit) exp_q.push_back('{a: {r.b, 1'b0}, d: r.a});
    exp_q.push_back('{a: {r.b, 1'b1}, d: r.d});
    m_cv  = 1;
    m_key = {r.b, r.a};
    return hit ? T_CAC : T_UNC;
  endfunction

  task automatic wait_idle(input string tag, input int limit, output int tend);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    tend = cyc;
  endtask

  task automatic cmp_pulses(input string tag);
    pulse_t  o;
    epulse_t e;
    chk({tag, "_npulse"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_addr"},   o.a, e.a);
      chk({tag, "_data"},   o.d, e.d);
      chk({tag, "_width"},  o.w, WRC);
      chk({tag, "_stable"}, o.st, 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_req(input req_t r);
    req_valid = 1'b1;
    req_bank  = r.b;
    req_addr  = r.a;
    req_data  = r.d;
  endtask

  // push everything in rq on consecutive cycles into an idle block, then
  // check the total time to idle and the pin pulses
  task automatic run_burst(input string tag);
    int e0, tend, texp;
    e0   = 0;
    texp = 0;
    foreach (rq[i]) begin
      push_req(rq[i]);
      tick();
      if (i == 0) e0 = cyc + 1;
      texp += model_write(rq[i]) + ((i > 0) ? 1 : 0);
    end
    req_valid = 1'b0;
    rq.delete();
    wait_idle(tag, 2000, tend);
    chk({tag, "_time"}, tend - e0, texp);
    cmp_pulses(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     e0, k, tend, da, pop_b;
    req_t   r;
    logic [7:0] pool [3];
    pool = '{8'h28, 8'h30, 8'hA4};

    IC = 1'b0; req_valid = 1'b0; req_bank = 1'b0; req_addr = '0; req_data = '0;
    tick(); tick();
    chk("rst_cs", YM_CS, 1);
    chk("rst_wr", YM_WR, 1);
    chk("rst_rd", YM_RD, 1);
    chk("rst_address", YM_ADDRESS, 0);
    chk("rst_data", YM_DATA, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    IC = 1'b1;
    tick();

    // single uncached write, bank0 0x30 = 0x71
    r = '{b: 1'b0, a: 8'h30, d: 8'h71};
    push_req(r);
    tick();
    req_valid = 1'b0;
    chk("t1_busy_after_accept", busy, 1);
    chk("t1_count_after_accept", fifo_count, 1);
    chk("t1_cs_before_pop", YM_CS, 1);
    tick();
    e0 = cyc;
    chk("t1_cs_after_pop", YM_CS, 0);
    chk("t1_wr_after_pop", YM_WR, 1);
    chk("t1_addr_after_pop", YM_ADDRESS, 0);
    chk("t1_data_after_pop", YM_DATA, 8'h30);
    chk("t1_count_after_pop", fifo_count, 0);
    da = model_write(r);
    wait_idle("t1", 300, tend);
    chk("t1_time", tend - e0, T_UNC);
    if (obs_q.size() >= 2) begin
      chk("t1_first_fall", obs_q[0].fall - e0, 1);
      chk("t1_phase_spacing", obs_q[1].fall - obs_q[0].fall, WRC + GAP + 1);
    end
    cmp_pulses("t1");

    // same register twice: second write reuses the latched address
    rq.push_back('{b: 1'b1, a: 8'hA4, d: 8'h22});
    rq.push_back('{b: 1'b1, a: 8'hA4, d: 8'h23});
    run_burst("cached_pair");

    // fill: one write in flight, then five pushes; the fifth is dropped
    r = '{b: 1'($urandom), a: 8'($urandom), d: 8'($urandom)};
    push_req(r);
    tick();
    k  = cyc;
    e0 = k + 1;
    req_valid = 1'b0;
    da = model_write(r);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      r = '{b: 1'($urandom), a: 8'($urandom), d: 8'($urandom)};
      push_req(r);
      tick();
      chk($sformatf("fill_count_%0d", i), fifo_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      chk($sformatf("fill_ready_%0d", i), req_ready, (i + 1 < DEPTH) ? 1 : 0);
      if (i < DEPTH) da += 0 * model_write(r);
    end
    // hold a request through the cycle in which the full FIFO is popped
    push_req('{b: 1'b1, a: 8'hEE, d: 8'hEE});
    pop_b = e0 + T_UNC + 1;
    if (exp_q.size() > 0 && exp_q[0].a[0] == 1'b1) pop_b = e0 + T_CAC + 1;
    while (cyc < pop_b - 1) tick();
    chk("full_count_before_pop", fifo_count, DEPTH);
    chk("full_ready_before_pop", req_ready, 0);
    tick();
    req_valid = 1'b0;
    chk("full_count_after_pop", fifo_count, DEPTH - 1);
    wait_idle("fill", 1000, tend);
    cmp_pulses("fill");

    // bank alternation: addresses 0,1,2,3 on the pins
    rq.push_back('{b: 1'b0, a: 8'h28, d: 8'hF0});
    rq.push_back('{b: 1'b1, a: 8'h30, d: 8'h01});
    run_burst("bank_alt");

    // reset during the data-phase WR pulse, with a second request queued
    r = '{b: 1'b0, a: 8'h28, d: 8'h11};
    push_req(r);
    tick();
    e0 = cyc + 1;
    push_req('{b: 1'b1, a: 8'h55, d: 8'h66});
    tick();
    req_valid = 1'b0;
    while (cyc < e0 + 6) tick();
    chk("rst_mid_wr_low", YM_WR, 0);
    chk("rst_mid_address", YM_ADDRESS, 2'b01);
    IC = 1'b0;
    #1;
    chk("rst_mid_cs", YM_CS, 1);
    chk("rst_mid_wr", YM_WR, 1);
    chk("rst_mid_rd", YM_RD, 1);
    chk("rst_mid_address0", YM_ADDRESS, 0);
    chk("rst_mid_data0", YM_DATA, 0);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    IC = 1'b1;
    tick();
    tick();
    obs_q.delete();
    exp_q.delete();
    m_cv = 0;
    rq.push_back('{b: 1'b0, a: 8'h28, d: 8'h22});
    run_burst("after_reset");

    // random bursts over a small address pool to mix hits and misses
    for (int b = 0; b < 6; b++) begin
      int n, idx;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        idx = $urandom_range(0, 3);
        r.b = 1'($urandom_range(0, 1));
        r.a = (idx == 3) ? 8'($urandom) : pool[idx];
        r.d = 8'($urandom);
        rq.push_back(r);
      end
      run_burst($sformatf("rand%0d", b));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
